workers_cpu_0_cpu_mult_pipe: RTL and testbench

WORKERS_CPU_0_CPU_MULT_PIPE -- requirements
Module: workers_cpu_0_cpu_mult_pipe

---
 rtl/workers_cpu_0_cpu_mult_pipe.sv | 109 ++++++++++
 tb/tb_workers_cpu_0_cpu_mult_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/workers_cpu_0_cpu_mult_pipe.sv
// Pipelined integer multiplier built from 16x16 partial products, PIPE_STAGES deep.
// Define WORKERS_MULT_HIGH_EN to build the full product and the high-word ops.
module workers_cpu_0_cpu_mult_pipe #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic [1:0]        E_op,
    input  logic              E_valid,
    input  logic              M_en,
    input  logic              M_flush,
    output logic [DATA_W-1:0] M_mul_result,
    output logic              M_mul_valid,
    output logic              M_op_err
);

    localparam int NCHUNK = DATA_W / 16;
`ifdef WORKERS_MULT_HIGH_EN
    localparam bit LOW_ONLY = 1'b0;
    localparam int ACC_W    = 2 * DATA_W;
`else
    localparam bit LOW_ONLY = 1'b1;
    localparam int ACC_W    = DATA_W;
`endif

    // Unsigned sum of 16x16 partial products; the low-only build skips terms that
    // land entirely above bit DATA_W-1.
    function automatic logic [ACC_W-1:0] chunk_product(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
        logic [ACC_W-1:0] acc;
        logic [31:0]      pp;
        acc = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            for (int j = 0; j < NCHUNK; j++) begin
                if (!LOW_ONLY || (i + j) < NCHUNK) begin
                    pp  = {16'b0, a[16*i +: 16]} * {16'b0, b[16*j +: 16]};
                    acc = acc + (ACC_W'(pp) << (16 * (i + j)));
                end
            end
        end
        return acc;
    endfunction

    logic [ACC_W-1:0]  prod_full;
    logic [DATA_W-1:0] word_in;
    logic              err_in;

`ifdef WORKERS_MULT_HIGH_EN
    // Two's-complement operand weight of -2^(DATA_W-1) is removed by subtracting the
    // other operand shifted into the high word.
    function automatic logic [ACC_W-1:0] correct_sign(input logic [ACC_W-1:0]  p,
                                                      input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b,
                                                      input logic              a_signed,
                                                      input logic              b_signed);
        logic [ACC_W-1:0] r;
        r = p;
        if (a_signed && a[DATA_W-1]) r = r - {b, {DATA_W{1'b0}}};
        if (b_signed && b[DATA_W-1]) r = r - {a, {DATA_W{1'b0}}};
        return r;
    endfunction

    always_comb begin
        prod_full = correct_sign(chunk_product(E_src1, E_src2), E_src1, E_src2,
                                 (E_op == 2'b01) || (E_op == 2'b10), (E_op == 2'b01));
        word_in   = (E_op == 2'b00) ? prod_full[DATA_W-1:0] : prod_full[ACC_W-1:DATA_W];
        err_in    = 1'b0;
    end
`else
    always_comb begin
        prod_full = chunk_product(E_src1, E_src2);
        word_in   = prod_full;
        err_in    = (E_op != 2'b00);
    end
`endif

    logic [PIPE_STAGES-1:0] vld_p;
    logic [PIPE_STAGES-1:0] err_p;
    logic [DATA_W-1:0]      res_p [PIPE_STAGES];

    // Stage 0 captures the selected word; later stages form a shift line toward the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            err_p <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) res_p[s] <= '0;
        end else if (M_flush) begin
            vld_p <= '0;
            err_p <= '0;
        end else if (M_en) begin
            vld_p[0] <= E_valid;
            err_p[0] <= E_valid & err_in;
            res_p[0] <= word_in;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_p[s] <= vld_p[s-1];
                err_p[s] <= err_p[s-1];
                res_p[s] <= res_p[s-1];
            end
        end
    end

    assign M_mul_result = res_p[PIPE_STAGES-1];
    assign M_mul_valid  = vld_p[PIPE_STAGES-1];
    assign M_op_err     = err_p[PIPE_STAGES-1];

endmodule

// File: tb/tb_workers_cpu_0_cpu_mult_pipe.sv
// Self-checking bench for workers_cpu_0_cpu_mult_pipe (DATA_W=32, PIPE_STAGES=2),
// directed cases plus randomized traffic against a queue-based reference model.
module tb_workers_cpu_0_cpu_mult_pipe;

    localparam int DW = 32;
    localparam int PS = 2;
`ifdef WORKERS_MULT_HIGH_EN
    localparam bit HIGH = 1'b1;
`else
    localparam bit HIGH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] E_src1, E_src2;
    logic [1:0]    E_op;
    logic          E_valid, M_en, M_flush;
    logic [DW-1:0] M_mul_result;
    logic          M_mul_valid, M_op_err;

    workers_cpu_0_cpu_mult_pipe #(.DATA_W(DW), .PIPE_STAGES(PS)) dut (
        .clk(clk), .reset(reset), .E_src1(E_src1), .E_src2(E_src2), .E_op(E_op),
        .E_valid(E_valid), .M_en(M_en), .M_flush(M_flush),
        .M_mul_result(M_mul_result), .M_mul_valid(M_mul_valid), .M_op_err(M_op_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: 64-bit product of the extended operands, word chosen by op.
    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
        logic [63:0] xa, xb, p;
        if (!HIGH) return a * b;
        xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic ref_err(input logic [1:0] op);
        return !HIGH && (op != 2'b00);
    endfunction

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] w;
    } ent_t;

    // hist[0] is what the output must show; an accepted op enters at the back and
    // reaches the front after PS enabled edges.
    ent_t hist[$];
    bit   model_ready = 0;
    bit   rst_clean   = 0;

    initial forever begin
        ent_t n;
        @(negedge clk);
        if (model_ready) begin
            check("valid", 32'(M_mul_valid), 32'(hist[0].v));
            check("op_err", 32'(M_op_err), 32'(hist[0].e));
            if (hist[0].v || rst_clean) check("result", M_mul_result, hist[0].w);
        end
        if (reset) begin
            hist = {};
            for (int i = 0; i < PS; i++) hist.push_back('0);
            model_ready = 1;
            rst_clean   = 1;
        end else if (model_ready && M_flush) begin
            foreach (hist[i]) begin
                hist[i].v = 1'b0;
                hist[i].e = 1'b0;
            end
        end else if (model_ready && M_en) begin
            n.v = E_valid;
            n.e = E_valid & ref_err(E_op);
            n.w = ref_word(E_src1, E_src2, E_op);
            hist.push_back(n);
            void'(hist.pop_front());
            rst_clean = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic v);
        E_src1  = a;
        E_src2  = b;
        E_op    = op;
        E_valid = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp31 [4];

    initial begin
        reset = 1'b1; M_en = 1'b1; M_flush = 1'b0;
        drive(32'h0, 32'h0, 2'b00, 1'b0);
        cyc(); cyc();
        check("reset_valid", 32'(M_mul_valid), 32'd0);
        check("reset_err", 32'(M_op_err), 32'd0);
        check("reset_result", M_mul_result, 32'd0);
        reset = 1'b0;

        // 3 x 5: result exactly two cycles after acceptance
        drive(32'd3, 32'd5, 2'b00, 1'b1);
        cyc();
        drive(32'd0, 32'd0, 2'b00, 1'b0);
        check("lat_early_valid", 32'(M_mul_valid), 32'd0);
        cyc();
        check("lat_valid", 32'(M_mul_valid), 32'd1);
        check("lat_result", M_mul_result, 32'h0000000F);

        // all-ones operands through every op, back to back
        exp31 = HIGH ? '{32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}
                     : '{32'h1, 32'h1, 32'h1, 32'h1};
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(32'hFFFFFFFF, 32'hFFFFFFFF, 2'(k), 1'b1);
            else       drive(32'h0, 32'h0, 2'b00, 1'b0);
            cyc();
            if (k >= 1) begin
                check("ones_valid", 32'(M_mul_valid), 32'd1);
                check("ones_result", M_mul_result, exp31[k-1]);
                check("ones_err", 32'(M_op_err), 32'((k - 1) != 0 && !HIGH));
            end
        end

        // stall holds output; 0x10000^2 op 11 completes after its second enabled edge
        drive(32'd3, 32'd5, 2'b00, 1'b1);
        cyc();
        drive(32'h00010000, 32'h00010000, 2'b11, 1'b1);
        cyc();
        M_en = 1'b0;
        drive(32'h1234, 32'h5678, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_valid", 32'(M_mul_valid), 32'd1);
            check("stall_result", M_mul_result, 32'h0000000F);
        end
        M_en = 1'b1;
        drive(32'h0, 32'h0, 2'b00, 1'b0);
        cyc();
        check("stall_done_valid", 32'(M_mul_valid), 32'd1);
        check("stall_done_result", M_mul_result, HIGH ? 32'h1 : 32'h0);
        check("stall_done_err", 32'(M_op_err), 32'(!HIGH));
        cyc();
        check("stall_ignored", 32'(M_mul_valid), 32'd0);

        // flush together with stall discards both in-flight ops
        drive(32'd6, 32'd7, 2'b00, 1'b1);
        cyc();
        drive(32'd8, 32'd9, 2'b00, 1'b1);
        cyc();
        M_en = 1'b0; M_flush = 1'b1;
        cyc();
        M_en = 1'b1; M_flush = 1'b0;
        drive(32'h0, 32'h0, 2'b00, 1'b0);
        check("flush_valid0", 32'(M_mul_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("flush_valid", 32'(M_mul_valid), 32'd0);
        end
        drive(32'd11, 32'd13, 2'b00, 1'b1);
        cyc();
        drive(32'h0, 32'h0, 2'b00, 1'b0);
        cyc();
        check("post_flush_valid", 32'(M_mul_valid), 32'd1);
        check("post_flush_result", M_mul_result, 32'd143);

        // reset one stage before completion
        drive(32'd7, 32'd9, 2'b00, 1'b1);
        cyc();
        drive(32'h0, 32'h0, 2'b00, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_mid_valid", 32'(M_mul_valid), 32'd0);
        check("rst_mid_result", M_mul_result, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("rst_mid_never", 32'(M_mul_valid), 32'd0);
        end

        // 2 x 0x80000000: op 01 then op 00
        drive(32'd2, 32'h80000000, 2'b01, 1'b1);
        cyc();
        drive(32'd2, 32'h80000000, 2'b00, 1'b1);
        cyc();
        check("sgn_result", M_mul_result, HIGH ? 32'hFFFFFFFF : 32'h0);
        check("sgn_err", 32'(M_op_err), 32'(!HIGH));
        drive(32'h0, 32'h0, 2'b00, 1'b0);
        cyc();
        check("low_result", M_mul_result, 32'h0);
        check("low_err", 32'(M_op_err), 32'd0);

        // randomized traffic with stalls, flushes and occasional reset
        for (int k = 0; k < 3000; k++) begin
            reset   = ($urandom_range(0, 99) == 0);
            M_flush = ($urandom_range(0, 19) == 0);
            M_en    = ($urandom_range(0, 4) != 0);
            E_valid = ($urandom_range(0, 3) != 0);
            E_op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       E_src1 = 32'hFFFFFFFF;
                1:       E_src1 = 32'h80000000;
                default: E_src1 = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       E_src2 = 32'hFFFFFFFF;
                1:       E_src2 = 32'h7FFFFFFF;
                default: E_src2 = $urandom;
            endcase
            cyc();
        end
        reset = 1'b0; M_flush = 1'b0; M_en = 1'b1; E_valid = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
